// File: rtl/imm_gen_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe_if
// Brief    : Handshake bundle between decode and the pipelined immediate generator.
// Revision : 1.0
// ============================================================================
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_inst;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_inst, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag
  );

  modport master (
    output in_valid, in_inst, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag
  );
endinterface
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Brief    : Registered immediate decoder with valid/ready, skid buffer, flush and tag.
// Revision : 1.0
// ============================================================================
module imm_gen_pipe #(
  parameter int XLEN    = 32,
  parameter int TAG_W   = 32,
  parameter int SUB_NEG = 1
) (
  input  wire logic           clk,
  input  wire logic           reset,
  input  wire logic           flush,
  imm_gen_pipe_if.slave       bus
);
  localparam logic [6:0] c_op_imm  = 7'b0010011;
  localparam logic [6:0] c_op_load = 7'b0000011;
  localparam logic [6:0] c_op_jalr = 7'b1100111;
  localparam logic [6:0] c_op_st   = 7'b0100011;
  localparam logic [6:0] c_op_br   = 7'b1100011;
  localparam logic [6:0] c_op_jal  = 7'b1101111;
  localparam logic [6:0] c_op_lui  = 7'b0110111;
  localparam logic [6:0] c_op_auipc= 7'b0010111;

  localparam logic [2:0] c_fmt_i    = 3'd0;
  localparam logic [2:0] c_fmt_s    = 3'd1;
  localparam logic [2:0] c_fmt_b    = 3'd2;
  localparam logic [2:0] c_fmt_u    = 3'd3;
  localparam logic [2:0] c_fmt_j    = 3'd4;
  localparam logic [2:0] c_fmt_none = 3'd7;

  logic [31:0]     w_inst;
  logic            w_sign;
  logic [XLEN-1:0] w_imm_i;
  logic            w_is_sub;
  logic [XLEN-1:0] w_dec_imm;
  logic [2:0]      w_dec_fmt;

  assign w_inst  = bus.in_inst;
  assign w_sign  = w_inst[31];
  assign w_imm_i = {{(XLEN-12){w_sign}}, w_inst[31:20]};

  // ADDI with a SUB-style funct7 is treated as a subtract-immediate hazard
  generate
    if (SUB_NEG != 0) begin : g_sub_neg
      assign w_is_sub = (w_inst[6:0] == c_op_imm) && (w_inst[31:25] == 7'b0100000)
                        && (w_inst[14:12] == 3'b000);
    end else begin : g_no_sub_neg
      assign w_is_sub = 1'b0;
    end
  endgenerate

  always_comb begin
    w_dec_imm = '0;
    w_dec_fmt = c_fmt_none;
    case (w_inst[6:0])
      c_op_imm, c_op_load, c_op_jalr: begin
        w_dec_imm = w_is_sub ? -w_imm_i : w_imm_i;
        w_dec_fmt = c_fmt_i;
      end
      c_op_st: begin
        w_dec_imm = {{(XLEN-12){w_sign}}, w_inst[31:25], w_inst[11:7]};
        w_dec_fmt = c_fmt_s;
      end
      c_op_br: begin
        w_dec_imm = {{(XLEN-13){w_sign}}, w_inst[31], w_inst[7], w_inst[30:25],
                     w_inst[11:8], 1'b0};
        w_dec_fmt = c_fmt_b;
      end
      c_op_jal: begin
        w_dec_imm = {{(XLEN-21){w_sign}}, w_inst[31], w_inst[19:12], w_inst[20],
                     w_inst[30:21], 1'b0};
        w_dec_fmt = c_fmt_j;
      end
      c_op_lui, c_op_auipc: begin
        w_dec_imm = {{(XLEN-32){w_sign}}, w_inst[31:12], 12'h000};
        w_dec_fmt = c_fmt_u;
      end
      default: begin
        w_dec_imm = '0;
        w_dec_fmt = c_fmt_none;
      end
    endcase
  end

  logic             main_valid_q, main_valid_d;
  logic [XLEN-1:0]  main_imm_q,   main_imm_d;
  logic [2:0]       main_fmt_q,   main_fmt_d;
  logic [TAG_W-1:0] main_tag_q,   main_tag_d;
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [2:0]       skid_fmt_q,   skid_fmt_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  logic w_in_ready;
  logic w_accept;
  logic w_main_free;

  assign w_in_ready  = !skid_valid_q && !reset && !flush;
  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_main_free = !main_valid_q || bus.out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_imm_d   = main_imm_q;
    main_fmt_d   = main_fmt_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (w_main_free) begin
      // skid is always older than any new beat, so it refills main first
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_imm_d   = skid_imm_q;
        main_fmt_d   = skid_fmt_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (w_accept) begin
        main_valid_d = 1'b1;
        main_imm_d   = w_dec_imm;
        main_fmt_d   = w_dec_fmt;
        main_tag_d   = bus.in_tag;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_valid_d = 1'b1;
      skid_imm_d   = w_dec_imm;
      skid_fmt_d   = w_dec_fmt;
      skid_tag_d   = bus.in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_q <= 1'b0;
      main_imm_q   <= '0;
      main_fmt_q   <= '0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= '0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_imm_q   <= main_imm_d;
      main_fmt_q   <= main_fmt_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = main_valid_q;
  assign bus.out_imm   = main_imm_q;
  assign bus.out_fmt   = main_fmt_q;
  assign bus.out_tag   = main_tag_q;
endmodule
`default_nettype wire
